sync_edge_filter: RTL and testbench
===================================

SYNC_EDGE_FILTER -- requirements
Module: sync_edge_filter

Interface
REQ-001 Parameter: NUM_CH, default 2, number of independent sync channels (1..16).
REQ-002 Parameter: CNT_W, default 8, debounce counter width.
REQ-003 Parameter: PER_W, default 24, period counter width.
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 sync_i  input  NUM_CH  raw external sync signals, asynchronous to clk.
REQ-007 invert_i  input  NUM_CH  per-channel polarity select; 1 = invert after synchronisation.
REQ-008 en_i  input  1  global enable.
REQ-009 stable_cnt_i  input  CNT_W  required consecutive stable cycles K before the filtered level changes.
REQ-010 sync_o  output  NUM_CH  filtered, polarity-corrected level.
REQ-011 redge_o  output  NUM_CH  one-cycle pulse on filtered rising edge.
REQ-012 fedge_o  output  NUM_CH  one-cycle pulse on filtered falling edge.
REQ-013 period_o  output  NUM_CH*PER_W  rising-to-rising period in clk cycles; channel n occupies bits [n*PER_W +: PER_W].
REQ-014 period_vld_o  output  NUM_CH  one-cycle strobe, period_o[n] updated.
REQ-015 period_ovf_o  output  NUM_CH  one-cycle strobe with period_vld_o; the period saturated.

Function
REQ-016 Each sync_i bit SHALL pass a 2-flop synchronizer, then XOR with invert_i, giving raw level r.
REQ-017 Per channel: counter c (CNT_W) and filtered level f, with sync_o = f.
REQ-018 If r == f, c SHALL clear to 0.
REQ-019 If r != f and c+1 < Keff, c SHALL increment; Keff = max(stable_cnt_i, 1).
REQ-020 If r != f and c+1 >= Keff, f SHALL take r and c SHALL clear.
REQ-021 Glitch rule: r differing from f for fewer than Keff consecutive cycles SHALL leave f unchanged.
REQ-022 Latency: a sync_i transition held stable SHALL change sync_o on the (2+Keff)-th rising clk edge after the first edge that samples the new value.
REQ-023 redge_o/fedge_o SHALL be registered and asserted in exactly the cycle sync_o first shows the new level; never both high on one channel.
REQ-024 stable_cnt_i changes SHALL take effect the next cycle; if c already >= the new Keff-1 while r != f, f SHALL update on that cycle.
REQ-025 Period counter p (PER_W) per channel SHALL increment every enabled cycle and saturate at all-ones.
REQ-026 On redge: if the channel is armed, period_o[n] <= p+1 (saturated) and period_vld_o[n] pulses; p clears; the channel becomes armed.
REQ-027 The first filtered rising edge after reset or enable SHALL only arm the channel; no period_vld_o.
REQ-028 period_ovf_o[n] SHALL pulse with period_vld_o[n] when p was all-ones at the edge; period_o then reads all-ones.
REQ-029 period_o SHALL hold its last value until the next valid strobe.
REQ-030 en_i low: synchronizers keep running; c cleared; f held; no edge/vld/ovf pulses; p cleared; channels disarmed.
REQ-031 Channels SHALL be fully independent; simultaneous events on different channels are handled in parallel.

Reset
REQ-032 reset_n low SHALL asynchronously clear the synchronizers, c, f, p, the armed flags, sync_o, redge_o, fedge_o, period_o, period_vld_o and period_ovf_o to 0.
REQ-033 After reset release, a constant-high r SHALL produce one redge_o after Keff cycles (f resets to 0); no period_vld_o.
REQ-034 Reset asserted mid-filter or mid-period SHALL discard all partial state; no pulse is emitted on release.

Verification
REQ-035 K=4, NUM_CH=2, ch0 0->1 held -> sync_o[0] and redge_o[0] high on edge 6 after the first sampling edge; redge_o one cycle wide; ch1 unaffected.
REQ-036 K=4, 3-cycle high glitch on ch0, then a 4-cycle high pulse -> no edge for the glitch; one redge and one fedge for the pulse.
REQ-037 K=2, square wave of period 100 cycles on ch0 -> first redge arms only; each later redge gives period_vld_o with period_o[0]=100.
REQ-038 PER_W=8, 300-cycle spacing between rising edges -> period_o=255 with period_ovf_o and period_vld_o pulsed together.
REQ-039 invert_i[1]=1, sync_i[1] 1->0 -> redge_o[1] pulses; stable_cnt_i=0 behaves as K=1 (latency 3).
REQ-040 en_i dropped mid-period, then reasserted; reset_n pulsed mid-filter -> no pulses; the next first redge only re-arms.

Source files
------------

// File: rtl/sync_edge_filter.sv
// Multi-channel sync input conditioner: 2-flop synchronizer, polarity select,
// K-cycle debounce, registered edge pulses and rising-to-rising period measurement.
module sync_edge_filter #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8,
  parameter int PER_W  = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         sync_i,
  input  logic [NUM_CH-1:0]         invert_i,
  input  logic                      en_i,
  input  logic [CNT_W-1:0]          stable_cnt_i,
  output logic [NUM_CH-1:0]         sync_o,
  output logic [NUM_CH-1:0]         redge_o,
  output logic [NUM_CH-1:0]         fedge_o,
  output logic [NUM_CH*PER_W-1:0]   period_o,
  output logic [NUM_CH-1:0]         period_vld_o,
  output logic [NUM_CH-1:0]         period_ovf_o
);

  logic [NUM_CH-1:0] meta;
  logic [NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0] raw;
  logic [CNT_W-1:0]  keff;

  // The synchronizers run regardless of en_i so re-enabling sees a settled level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep meta->sync_q a true two-stage shift
      // regardless of statement order; blocking here would collapse it to one flop.
      meta   <= sync_i;
      sync_q <= meta;
    end
  end

  assign raw  = sync_q ^ invert_i;
  assign keff = (stable_cnt_i == '0) ? CNT_W'(1) : stable_cnt_i;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             flt;
    logic             red;
    logic             fed;
    logic             vld;
    logic             ovf;
    logic             armed;
    logic [PER_W-1:0] per;
    logic [PER_W-1:0] per_out;
    logic             take;
    logic             rise;
    logic             fall;
    logic             per_max;

    // cnt counts consecutive cycles raw has disagreed with flt; one extra bit
    // keeps the compare against keff free of wrap-around.
    assign cnt_inc = {1'b0, cnt} + 1'b1;
    assign take    = en_i && (raw[n] != flt) && (cnt_inc >= {1'b0, keff});
    assign rise    = take && raw[n];
    assign fall    = take && !raw[n];
    assign per_max = &per;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt     <= '0;
        flt     <= 1'b0;
        red     <= 1'b0;
        fed     <= 1'b0;
        vld     <= 1'b0;
        ovf     <= 1'b0;
        armed   <= 1'b0;
        per     <= '0;
        per_out <= '0;
      end else begin
        red <= rise;
        fed <= fall;
        vld <= rise && armed;
        ovf <= rise && armed && per_max;
        if (!en_i) begin
          cnt   <= '0;
          per   <= '0;
          armed <= 1'b0;
        end else begin
          if ((raw[n] == flt) || take) cnt <= '0;
          else                         cnt <= cnt_inc[CNT_W-1:0];
          if (take) flt <= raw[n];
          // A period spans edge-to-edge, so the edge cycle itself adds one.
          if (rise) begin
            per   <= '0;
            armed <= 1'b1;
            if (armed) per_out <= per_max ? per : per + 1'b1;
          end else if (!per_max) begin
            per <= per + 1'b1;
          end
        end
      end
    end

    assign sync_o[n]                  = flt;
    assign redge_o[n]                 = red;
    assign fedge_o[n]                 = fed;
    assign period_vld_o[n]            = vld;
    assign period_ovf_o[n]            = ovf;
    assign period_o[n*PER_W +: PER_W] = per_out;
  end

endmodule

// File: tb/tb_sync_edge_filter.sv
// Randomized + directed bench for sync_edge_filter: a behavioural model predicts
// every cycle's outputs and each period event; a negedge monitor scores the DUT.
module tb_sync_edge_filter;
  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 8;
  localparam int PER_W   = 8;
  localparam int PER_MAX = (1 << PER_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NUM_CH-1:0]       sync_i = '0;
  logic [NUM_CH-1:0]       invert_i = '0;
  logic                    en_i = 1'b1;
  logic [CNT_W-1:0]        stable_cnt_i = CNT_W'(4);
  logic [NUM_CH-1:0]       sync_o, redge_o, fedge_o, period_vld_o, period_ovf_o;
  logic [NUM_CH*PER_W-1:0] period_o;

  always #5 clk = ~clk;

  sync_edge_filter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sync_i       (sync_i),
    .invert_i     (invert_i),
    .en_i         (en_i),
    .stable_cnt_i (stable_cnt_i),
    .sync_o       (sync_o),
    .redge_o      (redge_o),
    .fedge_o      (fedge_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .period_ovf_o (period_ovf_o)
  );

  typedef struct packed {
    logic [NUM_CH-1:0]       lvl;
    logic [NUM_CH-1:0]       red;
    logic [NUM_CH-1:0]       fed;
    logic [NUM_CH-1:0]       vld;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH*PER_W-1:0] per;
  } cyc_t;

  typedef struct {
    int ch;
    int cyc;
    int per;
    int ovf;
  } pev_t;

  cyc_t exp_q[$];
  pev_t per_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycle    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
    end
  endtask

  // Model: r is the sample taken two edges earlier (xor polarity); the filtered
  // level flips once r has disagreed with it for keff consecutive cycles.
  logic [NUM_CH-1:0] m_flt;
  logic [NUM_CH-1:0] m_samples[$];
  int                m_streak[NUM_CH];
  int                m_elapsed[NUM_CH];
  bit                m_armed[NUM_CH];
  int                m_last[NUM_CH];

  always @(posedge clk) begin : model
    cyc_t              e;
    logic [NUM_CH-1:0] r;
    int                keff;
    pev_t              ev;
    bit                rose;
    cycle++;
    e = '0;
    if (!reset_n) begin
      m_samples = {};
      m_flt     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_streak[c] = 0; m_elapsed[c] = 0; m_armed[c] = 0; m_last[c] = 0;
      end
    end else begin
      r = (m_samples.size() >= 2) ? m_samples[m_samples.size()-2] : '0;
      r = r ^ invert_i;
      m_samples.push_back(sync_i);
      if (m_samples.size() > 2) void'(m_samples.pop_front());
      keff = (stable_cnt_i == 0) ? 1 : int'(stable_cnt_i);
      for (int c = 0; c < NUM_CH; c++) begin
        rose = 0;
        if (!en_i) begin
          m_streak[c] = 0; m_elapsed[c] = 0; m_armed[c] = 0;
        end else begin
          if (r[c] == m_flt[c]) m_streak[c] = 0;
          else if (m_streak[c] + 1 >= keff) begin
            m_flt[c]    = r[c];
            m_streak[c] = 0;
            if (r[c]) begin e.red[c] = 1'b1; rose = 1; end
            else      e.fed[c] = 1'b1;
          end else m_streak[c]++;
          if (rose) begin
            if (m_armed[c]) begin
              ev.ch  = c;
              ev.cyc = cycle;
              ev.ovf = (m_elapsed[c] + 1 > PER_MAX) ? 1 : 0;
              ev.per = ev.ovf ? PER_MAX : m_elapsed[c] + 1;
              m_last[c] = ev.per;
              e.vld[c]  = 1'b1;
              e.ovf[c]  = ev.ovf[0];
              per_q.push_back(ev);
            end
            m_armed[c]   = 1;
            m_elapsed[c] = 0;
          end else m_elapsed[c]++;
        end
      end
    end
    e.lvl = m_flt;
    for (int c = 0; c < NUM_CH; c++) e.per[c*PER_W +: PER_W] = PER_W'(m_last[c]);
    exp_q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    cyc_t e;
    pev_t ev;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (!reset_n) begin
        check("reset_state", 64'({sync_o, redge_o, fedge_o, period_vld_o, period_ovf_o, period_o}), 64'(0));
        per_q = {};
      end else begin
        check("sync_o",       64'(sync_o),       64'(e.lvl));
        check("redge_o",      64'(redge_o),      64'(e.red));
        check("fedge_o",      64'(fedge_o),      64'(e.fed));
        check("period_vld_o", 64'(period_vld_o), 64'(e.vld));
        check("period_ovf_o", 64'(period_ovf_o), 64'(e.ovf));
        check("period_o",     64'(period_o),     64'(e.per));
        for (int c = 0; c < NUM_CH; c++) begin
          if (period_vld_o[c]) begin
            check("period_event_pending", 64'(per_q.size() != 0), 64'(1));
            if (per_q.size() != 0) begin
              ev = per_q.pop_front();
              check("period_event_ch",    64'(c),                            64'(ev.ch));
              check("period_event_cycle", 64'(cycle),                        64'(ev.cyc));
              check("period_event_value", 64'(period_o[c*PER_W +: PER_W]),   64'(ev.per));
              check("period_event_ovf",   64'(period_ovf_o[c]),              64'(ev.ovf));
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_ch0(input int high, input int low, input int reps);
    repeat (reps) begin
      sync_i[0] = 1'b1; tick(high);
      sync_i[0] = 1'b0; tick(low);
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    tick(3);
    reset_n = 1'b1;
    tick(8);
    // Single held edge with K=4, then glitch vs. real pulse.
    sync_i[0] = 1'b1; tick(12);
    sync_i[0] = 1'b0; tick(12);
    sync_i[0] = 1'b1; tick(3);
    sync_i[0] = 1'b0; tick(10);
    pulse_ch0(4, 12, 1);
    // K=2 square wave of period 100, then 300-cycle spacing to saturate.
    stable_cnt_i = CNT_W'(2);
    pulse_ch0(50, 50, 4);
    pulse_ch0(10, 290, 3);
    // Inverted ch1 with K=0 (acts as K=1).
    stable_cnt_i = '0;
    sync_i[1] = 1'b1; invert_i[1] = 1'b1; tick(8);
    sync_i[1] = 1'b0; tick(8);
    sync_i[1] = 1'b1; tick(8);
    // Enable dropped mid-period, then reset pulsed mid-filter.
    stable_cnt_i = CNT_W'(3);
    pulse_ch0(20, 20, 2);
    sync_i[0] = 1'b1; tick(5);
    en_i = 1'b0; tick(10);
    en_i = 1'b1; sync_i[0] = 1'b0; tick(10);
    pulse_ch0(15, 15, 3);
    sync_i[0] = 1'b1; tick(3);
    reset_n = 1'b0; tick(2);
    reset_n = 1'b1; tick(10);
    pulse_ch0(15, 15, 3);
    // Random traffic including K changes, polarity flips, enable and reset events.
    for (int i = 0; i < 5000; i++) begin
      for (int c = 0; c < NUM_CH; c++)
        if ($urandom_range(0, 7) == 0) sync_i[c] = ~sync_i[c];
      if ($urandom_range(0, 199) == 0) stable_cnt_i = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) invert_i = NUM_CH'($urandom);
      if ($urandom_range(0, 399) == 0) en_i = ~en_i;
      if ($urandom_range(0, 999) == 0) begin
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
      end
      tick();
    end
    en_i = 1'b1;
    tick(20);
    @(negedge clk);
    #1;
    check("period_queue_drained", 64'(per_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
